// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one memory bus between up to
// four requesters. It grants one port at a time and holds the grant until
// ready, fault, timeout or abort. Bus outputs and the per-port ready, fault
// and read-data returns are combinational on the registered grant.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus quiet; choose the next requester after last_grant
// BUSY  | bus driven by the granted port; wait for ready/fault/timeout
module mem_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*NUM_PORTS-1:0] req_address_in,
  input  logic [NUM_PORTS-1:0]    req_read_in,
  input  logic [NUM_PORTS-1:0]    req_write_in,
  input  logic [4*NUM_PORTS-1:0]  req_write_mask_in,
  input  logic [32*NUM_PORTS-1:0] req_write_value_in,
  output logic [32*NUM_PORTS-1:0] req_read_value_out,
  output logic [NUM_PORTS-1:0]    req_ready_out,
  output logic [NUM_PORTS-1:0]    req_fault_out,
  output logic [31:0]             address_out,
  output logic                    read_out,
  output logic                    write_out,
  output logic [3:0]              write_mask_out,
  output logic [31:0]             write_value_out,
  input  logic [31:0]             read_value_in,
  input  logic                    ready_in,
  input  logic                    fault_in
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state, state_d;
  logic [1:0]     grant, grant_d;
  logic [1:0]     last_grant, last_grant_d;
  logic [7:0]     timer, timer_d;

  logic [NUM_PORTS-1:0] requesting;
  logic [1:0]     pick;
  logic           found;
  int             cand;

  logic [31:0]    sel_addr;
  logic           sel_read;
  logic           sel_write;
  logic [3:0]     sel_mask;
  logic [31:0]    sel_wval;
  logic           sel_req;

  logic           done;
  logic           timeout_hit;
  logic           complete;
  logic           strobe_fault;

  assign requesting = req_read_in | req_write_in;

  // Rotating priority: scan last_grant+1, last_grant+2, ... and take the first
  // requester. Comparing against a loop index keeps the port index in range
  // for every NUM_PORTS without narrow/wide index mismatches.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last_grant) + k) % NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!found && (j == cand) && requesting[j]) begin
          found = 1'b1;
          pick  = 2'(j);
        end
      end
    end
  end

  // Select the granted port's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_mask  = '0;
    sel_wval  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == 2'(i)) begin
        sel_addr  = req_address_in[32*i +: 32];
        sel_read  = req_read_in[i];
        sel_write = req_write_in[i];
        sel_mask  = req_write_mask_in[4*i +: 4];
        sel_wval  = req_write_value_in[32*i +: 32];
      end
    end
  end

  assign sel_req     = sel_read | sel_write;
  assign done        = ready_in | fault_in;
  assign timeout_hit = (timer == 8'(TIMEOUT - 1));

  // A dropped request is an abort: it ends the grant silently, even if the
  // slave or the watchdog would have completed in the same cycle. A real
  // ready in the timeout cycle wins, so fault then follows fault_in alone.
  assign complete     = (state == BUSY) && sel_req && (done || timeout_hit);
  assign strobe_fault = (state == BUSY) && sel_req && (fault_in || (!done && timeout_hit));

  // State, grant, rotation pointer and watchdog timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'(NUM_PORTS - 1);
      timer      <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      timer      <= timer_d;
    end
  end

  // Next-state: grant in IDLE, release on completion/timeout/abort in BUSY.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    timer_d      = timer;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          timer_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!sel_req || complete) begin
          last_grant_d = grant;
          state_d      = IDLE;
        end else begin
          timer_d = timer + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared bus drive and per-port return routing; everything is 0 in IDLE.
  always_comb begin
    address_out        = '0;
    read_out           = 1'b0;
    write_out          = 1'b0;
    write_mask_out     = '0;
    write_value_out    = '0;
    req_read_value_out = '0;
    req_ready_out      = '0;
    req_fault_out      = '0;
    if (state == BUSY) begin
      address_out     = sel_addr;
      read_out        = sel_read;
      write_out       = sel_write;
      write_mask_out  = sel_write ? sel_mask : 4'b0000;
      write_value_out = sel_wval;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant == 2'(i)) begin
          req_read_value_out[32*i +: 32] = read_value_in;
          req_ready_out[i]               = complete;
          req_fault_out[i]               = strobe_fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: table-driven check of the round-robin memory arbiter
// with three ports and a short watchdog, plus hand-written multi-cycle
// sequences for timeout, abort and reset mid-transaction.
module tb_mem_rr_arbiter;

  localparam int NP = 3;
  localparam int TO = 4;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A2 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'hA0A0_A0A0;
  localparam logic [31:0] W1 = 32'hB1B1_B1B1;
  localparam logic [31:0] W2 = 32'hC2C2_C2C2;
  localparam logic [3:0]  M1 = 4'b1111;
  localparam logic [3:0]  M2 = 4'b0101;

  logic            clk = 1'b0;
  logic            reset;
  logic [32*NP-1:0] req_address_in;
  logic [NP-1:0]   req_read_in;
  logic [NP-1:0]   req_write_in;
  logic [4*NP-1:0] req_write_mask_in;
  logic [32*NP-1:0] req_write_value_in;
  logic [32*NP-1:0] req_read_value_out;
  logic [NP-1:0]   req_ready_out;
  logic [NP-1:0]   req_fault_out;
  logic [31:0]     address_out;
  logic            read_out;
  logic            write_out;
  logic [3:0]      write_mask_out;
  logic [31:0]     write_value_out;
  logic [31:0]     read_value_in;
  logic            ready_in;
  logic            fault_in;

  logic [31:0]     a1;
  logic [3:0]      m0;

  int total = 0;
  int bad   = 0;

  assign req_address_in     = {A2, a1, A0};
  assign req_write_mask_in  = {M2, M1, m0};
  assign req_write_value_in = {W2, W1, W0};

  logic [69:0] bus_act;
  assign bus_act = {read_out, write_out, address_out, write_mask_out, write_value_out};

  mem_rr_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_address_in     (req_address_in),
    .req_read_in        (req_read_in),
    .req_write_in       (req_write_in),
    .req_write_mask_in  (req_write_mask_in),
    .req_write_value_in (req_write_value_in),
    .req_read_value_out (req_read_value_out),
    .req_ready_out      (req_ready_out),
    .req_fault_out      (req_fault_out),
    .address_out        (address_out),
    .read_out           (read_out),
    .write_out          (write_out),
    .write_mask_out     (write_mask_out),
    .write_value_out    (write_value_out),
    .read_value_in      (read_value_in),
    .ready_in           (ready_in),
    .fault_in           (fault_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a1;
    logic [3:0]  m0;
    logic        rdy;
    logic        flt;
    logic [31:0] rv;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wv;
    logic [2:0]  e_rdy;
    logic [2:0]  e_flt;
    logic [95:0] e_rv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and settle before sampling.
  task automatic drive(input logic [2:0] rd, input logic [2:0] wr, input logic rdy,
                       input logic flt, input logic [31:0] rv, input logic [31:0] a,
                       input logic [3:0] m);
    @(negedge clk);
    req_read_in   = rd;
    req_write_in  = wr;
    ready_in      = rdy;
    fault_in      = flt;
    read_value_in = rv;
    a1            = a;
    m0            = m;
    #2;
  endtask

  // IDLE cycle: slave strobes are asserted to show they are ignored.
  function automatic vec_t idle_row(input logic [2:0] rd, input logic [2:0] wr,
                                    input logic [31:0] a, input logic [3:0] m);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a1 = a; v.m0 = m;
    v.rdy = 1'b1; v.flt = 1'b0; v.rv = 32'h5A5A_5A5A;
    v.e_rd = 1'b0; v.e_wr = 1'b0; v.e_addr = '0; v.e_mask = '0; v.e_wv = '0;
    v.e_rdy = '0; v.e_flt = '0; v.e_rv = '0;
    return v;
  endfunction

  // BUSY cycle with port p granted (p chosen by hand from the rotation).
  function automatic vec_t busy_row(input logic [2:0] rd, input logic [2:0] wr,
                                    input logic [31:0] a, input logic [3:0] m,
                                    input logic rdy, input logic flt,
                                    input logic [31:0] rv, input logic [1:0] p);
    vec_t v;
    logic [3:0] pm;
    v.rd = rd; v.wr = wr; v.a1 = a; v.m0 = m;
    v.rdy = rdy; v.flt = flt; v.rv = rv;
    case (p)
      2'd0:    begin v.e_addr = A0; v.e_wv = W0; pm = m;  end
      2'd1:    begin v.e_addr = a;  v.e_wv = W1; pm = M1; end
      default: begin v.e_addr = A2; v.e_wv = W2; pm = M2; end
    endcase
    v.e_rd   = rd[p];
    v.e_wr   = wr[p];
    v.e_mask = wr[p] ? pm : 4'b0000;
    v.e_rdy  = (rdy || flt) ? (3'b001 << p) : 3'b000;
    v.e_flt  = flt ? (3'b001 << p) : 3'b000;
    v.e_rv   = {64'b0, rv} << (32 * int'(p));
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    req_read_in   = 3'b111;
    req_write_in  = 3'b000;
    ready_in      = 1'b1;
    fault_in      = 1'b0;
    read_value_in = 32'h1357_9BDF;
    a1            = 32'h0000_0010;
    m0            = 4'b0011;

    // Table: starts in the first BUSY cycle after reset (port 0 granted).
    vecs.push_back(busy_row(3'b111, 3'b000, 32'h10, 4'b0011, 1'b1, 1'b0, 32'h1111_1111, 2'd0));
    vecs.push_back(idle_row(3'b010, 3'b000, 32'h10, 4'b0011));
    vecs.push_back(busy_row(3'b010, 3'b000, 32'h10, 4'b0011, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'd1));
    for (int t = 0; t < 8; t++) begin
      vecs.push_back(idle_row(3'b011, 3'b000, 32'h10, 4'b0011));
      vecs.push_back(busy_row(3'b011, 3'b000, 32'h10, 4'b0011, 1'b1, 1'b0,
                              32'h100 + 32'(t), 2'(t % 2)));
    end
    vecs.push_back(idle_row(3'b000, 3'b001, 32'h10, 4'b0011));
    vecs.push_back(busy_row(3'b000, 3'b001, 32'h10, 4'b0011, 1'b1, 1'b0, 32'h55, 2'd0));
    vecs.push_back(idle_row(3'b001, 3'b000, 32'h10, 4'b1111));
    vecs.push_back(busy_row(3'b001, 3'b000, 32'h10, 4'b1111, 1'b1, 1'b0, 32'h66, 2'd0));
    vecs.push_back(idle_row(3'b010, 3'b000, 32'h8000_0000, 4'b1111));
    vecs.push_back(busy_row(3'b010, 3'b000, 32'h8000_0000, 4'b1111, 1'b0, 1'b1, 32'h1234_5678, 2'd1));
    vecs.push_back(idle_row(3'b111, 3'b000, 32'h10, 4'b0011));
    vecs.push_back(busy_row(3'b111, 3'b000, 32'h10, 4'b0011, 1'b1, 1'b0, 32'h0000_CAFE, 2'd2));
    vecs.push_back(idle_row(3'b111, 3'b000, 32'h10, 4'b0011));
    vecs.push_back(busy_row(3'b111, 3'b000, 32'h10, 4'b0011, 1'b1, 1'b0, 32'h0000_F00D, 2'd0));

    // Reset held with every port requesting and ready_in high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("reset_bus", 96'(bus_act), 96'd0);
    chk("reset_strobe", 96'({req_ready_out, req_fault_out}), 96'd0);
    chk("reset_rdata", 96'(req_read_value_out), 96'd0);
    @(negedge clk);
    reset    = 1'b0;
    ready_in = 1'b0;
    #2;
    chk("post_reset_idle_bus", 96'(bus_act), 96'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].rdy, vecs[i].flt, vecs[i].rv, vecs[i].a1, vecs[i].m0);
      chk($sformatf("vec%0d_bus", i), 96'(bus_act),
          96'({vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_mask, vecs[i].e_wv}));
      chk($sformatf("vec%0d_strobe", i), 96'({req_ready_out, req_fault_out}),
          96'({vecs[i].e_rdy, vecs[i].e_flt}));
      chk($sformatf("vec%0d_rdata", i), 96'(req_read_value_out), vecs[i].e_rv);
    end

    // Timeout: ports 1 and 2 request, slave never answers. last_grant is 0.
    drive(3'b110, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("to_idle", 96'(bus_act), 96'd0);
    for (int k = 0; k < 3; k++) begin
      drive(3'b110, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
      chk($sformatf("to_wait%0d_addr", k), 96'({read_out, address_out}), 96'({1'b1, 32'h10}));
      chk($sformatf("to_wait%0d_strobe", k), 96'({req_ready_out, req_fault_out}), 96'd0);
    end
    drive(3'b110, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("to_fire", 96'({req_ready_out, req_fault_out}), 96'({3'b010, 3'b010}));
    drive(3'b110, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("to_after_idle", 96'(bus_act), 96'd0);
    drive(3'b110, 3'b000, 1'b1, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("to_next_grant", 96'({read_out, address_out}), 96'({1'b1, A2}));
    chk("to_next_strobe", 96'({req_ready_out, req_fault_out}), 96'({3'b100, 3'b000}));

    // Ready arriving in the timeout cycle: ready wins, no fault. last_grant is 2.
    drive(3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    for (int k = 0; k < 3; k++) drive(3'b010, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("to_ready_pre", 96'({req_ready_out, req_fault_out}), 96'd0);
    drive(3'b010, 3'b000, 1'b1, 1'b0, 32'h77, 32'h10, 4'b0011);
    chk("to_ready_race", 96'({req_ready_out, req_fault_out}), 96'({3'b010, 3'b000}));

    // Abort: port 0 drops its read while BUSY. last_grant is 1.
    drive(3'b001, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    drive(3'b001, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("abort_granted", 96'({read_out, address_out}), 96'({1'b1, A0}));
    drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("abort_drop_strobe", 96'({req_ready_out, req_fault_out}), 96'd0);
    drive(3'b011, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("abort_idle", 96'(bus_act), 96'd0);
    drive(3'b011, 3'b000, 1'b1, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("abort_rotate", 96'({read_out, address_out}), 96'({1'b1, 32'h10}));
    chk("abort_rotate_strobe", 96'({req_ready_out, req_fault_out}), 96'({3'b010, 3'b000}));

    // Reset mid-transaction: bus drops at once, no strobe, port 0 wins after.
    drive(3'b001, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    drive(3'b001, 3'b000, 1'b0, 1'b0, 32'h0, 32'h10, 4'b0011);
    chk("midrst_busy", 96'({read_out, address_out}), 96'({1'b1, A0}));
    #1;
    reset    = 1'b1;
    ready_in = 1'b1;
    #1;
    chk("midrst_bus", 96'(bus_act), 96'd0);
    chk("midrst_strobe", 96'({req_ready_out, req_fault_out}), 96'd0);
    @(negedge clk);
    reset       = 1'b0;
    ready_in    = 1'b0;
    req_read_in = 3'b111;
    #2;
    chk("midrst_idle", 96'(bus_act), 96'd0);
    drive(3'b111, 3'b000, 1'b1, 1'b0, 32'h99, 32'h10, 4'b0011);
    chk("midrst_first", 96'({read_out, address_out}), 96'({1'b1, A0}));
    chk("midrst_first_strobe", 96'({req_ready_out, req_fault_out}), 96'({3'b001, 3'b000}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
